airi5c_fpu_result_collector: RTL and testbench
==============================================

Name: airi5c_fpu_result_collector

Overview:
Downstream stage of the FPU converter/arithmetic units, including the integer-to-float converter. It tracks one outstanding FPU operation, captures the result and exception flags from the unit that was issued the operation when that unit pulses ready, and holds the result until the core acknowledges it. It also keeps the sticky fflags register (NV DZ OF UF NX) and a watchdog against units that never respond.

Parameters:
N_UNITS, 4, number of attached FPU units; index 0 = itof, 1 = ftoi, 2 = addsub, 3 = muldiv.
TIMEOUT, 64, max cycles in WAIT before abort; must be ≥2 and <256.

Ports:
clk  in  1  clock
n_reset  in  1  asynchronous, active-low reset
kill  in  1  flush current op (pipeline kill)
load  in  1  new FPU op issued this cycle (same cycle the unit sees its load)
unit_sel  in  N_UNITS  one-hot target unit of load
unit_ready  in  N_UNITS  per-unit one-cycle ready pulses
unit_result  in  32*N_UNITS  per-unit result; unit i at [32i+31:32i]
unit_flags  in  5*N_UNITS  per-unit flags {NV,DZ,OF,UF,NX}; unit i at [5i+4:5i]
ack  in  1  core consumes result this cycle
fflags_we  in  1  CSR write to fflags
fflags_wdata  in  5  CSR write data
result  out  32  held FPU result
result_valid  out  1  result holds a valid value
busy  out  1  state != IDLE (core stall)
fflags  out  5  sticky accumulated flags
timeout_err  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset, asynchronous: state=IDLE; result=0, result_valid=0, busy=0, fflags=0, timeout_err=0, sel_reg=0, counter=0.
- All outputs are registered.
- States: IDLE, WAIT, HOLD.
- IDLE:
  - load with unit_sel≠0 → WAIT, sel_reg := lowest set bit of unit_sel (one-hot), counter := 0.
  - load with unit_sel==0 is ignored.
- WAIT:
  - counter increments each cycle.
  - unit_ready[k] with sel_reg[k] → capture result := unit_result[k], fflags |= unit_flags[k], result_valid := 1, → HOLD.
  - ready pulses from non-selected units are ignored.
  - A ready pulse in the load cycle itself is ignored; units respond at earliest the cycle after load, so minimum load→result_valid latency is 2 cycles.
  - counter reaches TIMEOUT-1 with no ready → result := 0, no flag update, result_valid := 1, timeout_err pulses 1 cycle, → HOLD.
  - load while in WAIT is a protocol violation and is ignored.
- HOLD:
  - result and result_valid stay stable until ack.
  - ack → result_valid := 0, → IDLE.
  - ack and load in the same cycle → directly WAIT with the new sel_reg; result_valid := 0.
  - load without ack is ignored.
- kill: highest priority, from any state. → IDLE, result_valid := 0, counter := 0. Any coincident ready is discarded with no flag accumulation. fflags is kept. A simultaneous fflags_we still applies.
- fflags_we: fflags := fflags_wdata | flags captured in the same cycle, so a CSR write never loses a concurrent exception.
- busy = 1 in WAIT and HOLD.
- Reset mid-operation: immediate return to reset values; a later stray ready pulse is ignored in IDLE.

Decomposition:
- Shared FPU package holds:
  - Unit index constants: UNIT_ITOF=0, UNIT_FTOI=1, UNIT_ADDSUB=2, UNIT_MULDIV=3.
  - Flag bit positions: NV=4, DZ=3, OF=2, UF=1, NX=0.
  - State encoding: IDLE=2'd0, WAIT=2'd1, HOLD=2'd2.
- One natural sub-module, airi5c_onehot_mux: parameterised one-hot select of 32-bit result plus 5-bit flags from the unit vectors. Everything else stays in the top module.

Test Plan:
- Basic capture:
  - Stimulus: load with unit_sel=0001; two cycles later unit_ready=0001, result 0x3F800000, flags 00000; ack one cycle later.
  - Response: result=0x3F800000, result_valid=1 the cycle after ready; busy=0 after ack; fflags=0.
- Flag accumulation across ops:
  - Stimulus: itof op with NX flag (00001), then addsub op with OF|NX (00101).
  - Response: fflags=00101 after second capture; fflags_we with 00000 in the same cycle as a ready carrying 00001 → fflags=00001.
- Wrong-unit ready:
  - Stimulus: sel=0010; unit_ready=0001 with result 0xDEADBEEF; next cycle unit_ready=0010 with result 0x12345678.
  - Response: result=0x12345678; 0xDEADBEEF never visible.
- Kill:
  - Stimulus: kill in WAIT, coincident with unit_ready for the selected unit, flags 10000.
  - Response: state=IDLE, result_valid=0, fflags unchanged.
- Timeout:
  - Stimulus: load, no ready for TIMEOUT=64 cycles.
  - Response: timeout_err pulse at cycle 64 after load; result=0, result_valid=1.
- Back-to-back:
  - Stimulus: ack and load (sel=0100) in the same cycle while in HOLD.
  - Response: result_valid drops; busy stays 1; next capture comes from unit 2.
- Async reset mid-WAIT:
  - Stimulus: assert n_reset low during WAIT.
  - Response: all outputs 0 immediately.

Source files
------------

// File: rtl/airi5c_fpu_result_collector_pkg.sv
// Shared FPU definitions for the result collector slice.
//   - Indices of the attached FPU units, as positions in the unit vectors.
//   - Bit positions in the 5-bit exception flag vector {NV,DZ,OF,UF,NX}.
//   - State encoding of the result collector FSM.
package airi5c_fpu_result_collector_pkg;

    localparam int unsigned RESULT_W = 32;
    localparam int unsigned FLAG_W   = 5;

    // Position of each unit in unit_sel / unit_ready / unit_result / unit_flags
    localparam int unsigned UNIT_ITOF   = 0;
    localparam int unsigned UNIT_FTOI   = 1;
    localparam int unsigned UNIT_ADDSUB = 2;
    localparam int unsigned UNIT_MULDIV = 3;

    // Exception flag bit positions
    localparam int unsigned FLAG_NV = 4;
    localparam int unsigned FLAG_DZ = 3;
    localparam int unsigned FLAG_OF = 2;
    localparam int unsigned FLAG_UF = 1;
    localparam int unsigned FLAG_NX = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/airi5c_onehot_mux.sv
// One-hot selection of a result word and its exception flags from the
// concatenated per-unit vectors.
// Ports:
//   sel      in  N_UNITS          one-hot unit select (all-zero selects 0)
//   results  in  32*N_UNITS       unit i at [32i+31:32i]
//   flags    in  5*N_UNITS        unit i at [5i+4:5i]
//   result   out 32               selected result
//   flag     out 5                selected flags
module airi5c_onehot_mux
    import airi5c_fpu_result_collector_pkg::*;
#(
    parameter int N_UNITS = 4
) (
    input  logic [N_UNITS-1:0]          sel,
    input  logic [RESULT_W*N_UNITS-1:0] results,
    input  logic [FLAG_W*N_UNITS-1:0]   flags,
    output logic [RESULT_W-1:0]         result,
    output logic [FLAG_W-1:0]           flag
);

    // AND-OR structure: with a one-hot select no priority chain is needed.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        result = '0;
        flag   = '0;
        for (int i = 0; i < N_UNITS; i++) begin
            result = result | ({RESULT_W{sel[i]}} & results[RESULT_W*i +: RESULT_W]);
            flag   = flag   | ({FLAG_W{sel[i]}}   & flags[FLAG_W*i +: FLAG_W]);
        end
    end

endmodule

// File: rtl/airi5c_fpu_result_collector.sv
// Tracks one outstanding FPU operation, captures the result/flags of the
// issued unit when it pulses ready, and holds the result until the core
// acknowledges it. Also keeps the sticky fflags register and a watchdog
// that aborts an operation whose unit never responds.
// Ports:
//   clk, n_reset       clock, asynchronous active-low reset
//   kill               flush the current operation (highest priority)
//   load, unit_sel     new operation and its one-hot target unit
//   unit_ready         per-unit one-cycle ready pulses
//   unit_result        per-unit 32-bit results, unit i at [32i+31:32i]
//   unit_flags         per-unit flags {NV,DZ,OF,UF,NX}, unit i at [5i+4:5i]
//   ack                core consumes the held result
//   fflags_we/_wdata   CSR write to fflags
//   result             held result (0 after a watchdog abort)
//   result_valid       result holds a valid value
//   busy               operation in flight or result not yet consumed
//   fflags             sticky accumulated flags
//   timeout_err        one-cycle pulse on watchdog abort
module airi5c_fpu_result_collector
    import airi5c_fpu_result_collector_pkg::*;
#(
    parameter int N_UNITS = 4,
    parameter int TIMEOUT = 64   // 2..255
) (
    input  logic                        clk,
    input  logic                        n_reset,
    input  logic                        kill,
    input  logic                        load,
    input  logic [N_UNITS-1:0]          unit_sel,
    input  logic [N_UNITS-1:0]          unit_ready,
    input  logic [RESULT_W*N_UNITS-1:0] unit_result,
    input  logic [FLAG_W*N_UNITS-1:0]   unit_flags,
    input  logic                        ack,
    input  logic                        fflags_we,
    input  logic [FLAG_W-1:0]           fflags_wdata,
    output logic [RESULT_W-1:0]         result,
    output logic                        result_valid,
    output logic                        busy,
    output logic [FLAG_W-1:0]           fflags,
    output logic                        timeout_err
);

    localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT - 1);

    state_t               state, state_next;
    logic [N_UNITS-1:0]   sel_reg, sel_next;
    logic [7:0]           counter, counter_next;
    logic [RESULT_W-1:0]  result_next;
    logic                 valid_next, busy_next, timeout_next;
    logic [FLAG_W-1:0]    fflags_next, captured_flags;

    logic [N_UNITS-1:0]   lowest_sel;
    logic                 new_op, ready_hit;
    logic [RESULT_W-1:0]  mux_result;
    logic [FLAG_W-1:0]    mux_flags;

    // Two's-complement trick isolates the lowest set bit of unit_sel, so a
    // malformed multi-hot select still targets exactly one unit.
    assign lowest_sel = unit_sel & (~unit_sel + {{(N_UNITS-1){1'b0}}, 1'b1});
    assign new_op     = load && (unit_sel != '0);
    assign ready_hit  = (unit_ready & sel_reg) != '0;

    airi5c_onehot_mux #(.N_UNITS(N_UNITS)) u_mux (
        .sel     (sel_reg),
        .results (unit_result),
        .flags   (unit_flags),
        .result  (mux_result),
        .flag    (mux_flags)
    );

    always_comb begin
        state_next     = state;
        sel_next       = sel_reg;
        counter_next   = counter;
        result_next    = result;
        valid_next     = result_valid;
        timeout_next   = 1'b0;
        captured_flags = '0;

        if (kill) begin
            // A coincident ready is dropped: captured_flags stays zero.
            state_next   = IDLE;
            valid_next   = 1'b0;
            counter_next = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (new_op) begin
                        state_next   = WAIT;
                        sel_next     = lowest_sel;
                        counter_next = '0;
                    end
                end
                WAIT: begin
                    counter_next = counter + 8'd1;
                    if (ready_hit) begin
                        result_next    = mux_result;
                        captured_flags = mux_flags;
                        valid_next     = 1'b1;
                        state_next     = HOLD;
                    end else if (counter == LAST_COUNT) begin
                        result_next  = '0;
                        valid_next   = 1'b1;
                        timeout_next = 1'b1;
                        state_next   = HOLD;
                    end
                end
                HOLD: begin
                    if (ack) begin
                        valid_next = 1'b0;
                        if (new_op) begin
                            state_next   = WAIT;
                            sel_next     = lowest_sel;
                            counter_next = '0;
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end

        // A CSR write merges with flags captured in the same cycle.
        fflags_next = (fflags_we ? fflags_wdata : fflags) | captured_flags;
        busy_next   = (state_next != IDLE);
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state        <= IDLE;
            sel_reg      <= '0;
            counter      <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            fflags       <= '0;
            timeout_err  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register update from
            // the pre-edge values, independent of statement order.
            state        <= state_next;
            sel_reg      <= sel_next;
            counter      <= counter_next;
            result       <= result_next;
            result_valid <= valid_next;
            busy         <= busy_next;
            fflags       <= fflags_next;
            timeout_err  <= timeout_next;
        end
    end

endmodule

// File: tb/tb_airi5c_fpu_result_collector.sv
// Self-checking bench for airi5c_fpu_result_collector. Inputs change and
// outputs are sampled on the falling clock edge; the DUT acts on the rising
// edge. Expected captures are queued when a ready pulse is driven and
// popped when the held result is checked.
module tb_airi5c_fpu_result_collector;
    import airi5c_fpu_result_collector_pkg::*;

    localparam int N  = 4;
    localparam int TO = 64;

    logic            clk = 1'b0;
    logic            n_reset = 1'b0;
    logic            kill = 1'b0, load = 1'b0, ack = 1'b0, fflags_we = 1'b0;
    logic [N-1:0]    unit_sel = '0, unit_ready = '0;
    logic [32*N-1:0] unit_result = '0;
    logic [5*N-1:0]  unit_flags = '0;
    logic [4:0]      fflags_wdata = '0;
    logic [31:0]     result;
    logic            result_valid, busy, timeout_err;
    logic [4:0]      fflags;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  flg;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       e;
    logic [4:0] model_fflags = '0;
    int         n_tests = 0;
    int         n_fail  = 0;

    always #5 clk = ~clk;

    airi5c_fpu_result_collector #(.N_UNITS(N), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .n_reset      (n_reset),
        .kill         (kill),
        .load         (load),
        .unit_sel     (unit_sel),
        .unit_ready   (unit_ready),
        .unit_result  (unit_result),
        .unit_flags   (unit_flags),
        .ack          (ack),
        .fflags_we    (fflags_we),
        .fflags_wdata (fflags_wdata),
        .result       (result),
        .result_valid (result_valid),
        .busy         (busy),
        .fflags       (fflags),
        .timeout_err  (timeout_err)
    );

    // Issue a load for one cycle; returns on the falling edge after it.
    task automatic drive_load(input logic [N-1:0] sel);
        load = 1'b1; unit_sel = sel;
        @(negedge clk);
        load = 1'b0; unit_sel = '0;
    endtask

    // One-cycle ready pulse from unit k; when expected, queue the capture.
    task automatic pulse_ready(input int k, input logic [31:0] r,
                               input logic [4:0] f, input bit expect_capture);
        unit_ready[k]          = 1'b1;
        unit_result[32*k +: 32] = r;
        unit_flags[5*k +: 5]    = f;
        if (expect_capture) begin
            model_fflags = (fflags_we ? fflags_wdata : model_fflags) | f;
            exp_q.push_back(exp_t'{res: r, flg: model_fflags});
        end
        @(negedge clk);
        unit_ready = '0;
    endtask

    task automatic do_ack();
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        n_tests++;
        if ({result, result_valid, busy, fflags, timeout_err} !== 40'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got res=%h v=%b busy=%b ff=%b to=%b, expected all 0",
                     result, result_valid, busy, fflags, timeout_err);
        end
        @(negedge clk);
        n_reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        drive_load(4'b0001);
        n_tests++;
        if ({busy, result_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL basic_wait: got busy=%b valid=%b, expected busy=1 valid=0", busy, result_valid);
        end
        @(negedge clk);
        pulse_ready(UNIT_ITOF, 32'h3F80_0000, 5'b00000, 1'b1);
        e = exp_q.pop_front();
        n_tests++;
        if ({result_valid, result, fflags} !== {1'b1, e.res, e.flg}) begin
            n_fail++;
            $display("FAIL basic_capture: got v=%b res=%h ff=%b, expected v=1 res=%h ff=%b",
                     result_valid, result, fflags, e.res, e.flg);
        end
        do_ack();
        n_tests++;
        if ({busy, result_valid, fflags} !== 7'd0) begin
            n_fail++;
            $display("FAIL basic_ack: got busy=%b valid=%b ff=%b, expected 0 0 00000", busy, result_valid, fflags);
        end
    endtask

    task automatic test_flags();
        // Ready on the cycle right after load: minimum latency path.
        drive_load(4'b0001);
        pulse_ready(UNIT_ITOF, 32'h4000_0000, 5'b00001, 1'b1);
        e = exp_q.pop_front();
        n_tests++;
        if ({result_valid, result, fflags} !== {1'b1, e.res, e.flg}) begin
            n_fail++;
            $display("FAIL flags_itof: got v=%b res=%h ff=%b, expected v=1 res=%h ff=%b",
                     result_valid, result, fflags, e.res, e.flg);
        end
        do_ack();
        drive_load(4'b0100);
        pulse_ready(UNIT_ADDSUB, 32'h4100_0000, 5'b00101, 1'b1);
        e = exp_q.pop_front();
        n_tests++;
        if ({result, fflags} !== {e.res, 5'b00101}) begin
            n_fail++;
            $display("FAIL flags_accum: got res=%h ff=%b, expected res=%h ff=00101", result, fflags, e.res);
        end
        do_ack();
        // CSR clear in the same cycle as a capture carrying NX.
        drive_load(4'b0001);
        fflags_we = 1'b1; fflags_wdata = 5'b00000;
        pulse_ready(UNIT_ITOF, 32'h4040_0000, 5'b00001, 1'b1);
        fflags_we = 1'b0;
        e = exp_q.pop_front();
        n_tests++;
        if ({result, fflags} !== {e.res, 5'b00001}) begin
            n_fail++;
            $display("FAIL flags_csr_merge: got res=%h ff=%b, expected res=%h ff=00001", result, fflags, e.res);
        end
        do_ack();
    endtask

    task automatic test_wrong_unit();
        // Ready from the target unit in the load cycle itself is ignored.
        unit_ready[UNIT_FTOI] = 1'b1;
        unit_result[32*UNIT_FTOI +: 32] = 32'hBAD0_BAD0;
        drive_load(4'b0010);
        unit_ready = '0;
        n_tests++;
        if (result_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL wrong_load_cycle_ready: got valid=%b, expected 0", result_valid);
        end
        pulse_ready(UNIT_ITOF, 32'hDEAD_BEEF, 5'b10000, 1'b0);
        n_tests++;
        if ({result_valid, fflags} !== {1'b0, model_fflags}) begin
            n_fail++;
            $display("FAIL wrong_unit_ignored: got valid=%b ff=%b res=%h, expected valid=0 ff=%b",
                     result_valid, fflags, result, model_fflags);
        end
        pulse_ready(UNIT_FTOI, 32'h1234_5678, 5'b00000, 1'b1);
        e = exp_q.pop_front();
        n_tests++;
        if ({result_valid, result, fflags} !== {1'b1, e.res, e.flg}) begin
            n_fail++;
            $display("FAIL wrong_unit_capture: got v=%b res=%h ff=%b, expected v=1 res=%h ff=%b",
                     result_valid, result, fflags, e.res, e.flg);
        end
        do_ack();
    endtask

    task automatic test_kill();
        drive_load(4'b0010);
        kill = 1'b1;
        pulse_ready(UNIT_FTOI, 32'h5555_AAAA, 5'b10000, 1'b0);
        kill = 1'b0;
        n_tests++;
        if ({busy, result_valid, fflags} !== {2'b00, model_fflags}) begin
            n_fail++;
            $display("FAIL kill_wait: got busy=%b valid=%b ff=%b, expected 0 0 %b",
                     busy, result_valid, fflags, model_fflags);
        end
        // Kill does not block a CSR write in the same cycle.
        kill = 1'b1; fflags_we = 1'b1; fflags_wdata = 5'b00010;
        @(negedge clk);
        kill = 1'b0; fflags_we = 1'b0;
        model_fflags = 5'b00010;
        n_tests++;
        if (fflags !== model_fflags) begin
            n_fail++;
            $display("FAIL kill_csr_write: got ff=%b, expected %b", fflags, model_fflags);
        end
    endtask

    task automatic test_timeout();
        bit early = 1'b0;
        drive_load(4'b1000);
        for (int i = 1; i < TO; i++) begin
            @(negedge clk);
            if (timeout_err || result_valid) early = 1'b1;
        end
        n_tests++;
        if (early) begin
            n_fail++;
            $display("FAIL timeout_early: got an abort or valid before cycle %0d, expected none", TO);
        end
        exp_q.push_back(exp_t'{res: 32'd0, flg: model_fflags});
        @(negedge clk);
        e = exp_q.pop_front();
        n_tests++;
        if ({timeout_err, result_valid, result, fflags} !== {2'b11, e.res, e.flg}) begin
            n_fail++;
            $display("FAIL timeout_abort: got to=%b v=%b res=%h ff=%b, expected to=1 v=1 res=%h ff=%b",
                     timeout_err, result_valid, result, fflags, e.res, e.flg);
        end
        @(negedge clk);
        n_tests++;
        if ({timeout_err, result_valid, busy} !== 3'b011) begin
            n_fail++;
            $display("FAIL timeout_pulse_len: got to=%b v=%b busy=%b, expected 0 1 1",
                     timeout_err, result_valid, busy);
        end
        do_ack();
    endtask

    task automatic test_back_to_back();
        drive_load(4'b0001);
        pulse_ready(UNIT_ITOF, 32'hAAAA_5555, 5'b00000, 1'b1);
        e = exp_q.pop_front();
        // Load without ack in HOLD is ignored.
        drive_load(4'b0010);
        n_tests++;
        if ({result_valid, result} !== {1'b1, e.res}) begin
            n_fail++;
            $display("FAIL b2b_hold_load: got v=%b res=%h, expected v=1 res=%h", result_valid, result, e.res);
        end
        ack = 1'b1;
        drive_load(4'b0100);
        ack = 1'b0;
        n_tests++;
        if ({result_valid, busy} !== 2'b01) begin
            n_fail++;
            $display("FAIL b2b_ack_load: got valid=%b busy=%b, expected valid=0 busy=1", result_valid, busy);
        end
        pulse_ready(UNIT_ADDSUB, 32'h0BAD_F00D, 5'b01000, 1'b1);
        e = exp_q.pop_front();
        n_tests++;
        if ({result_valid, result, fflags} !== {1'b1, e.res, e.flg}) begin
            n_fail++;
            $display("FAIL b2b_capture: got v=%b res=%h ff=%b, expected v=1 res=%h ff=%b",
                     result_valid, result, fflags, e.res, e.flg);
        end
        do_ack();
    endtask

    task automatic test_async_reset();
        drive_load(4'b0100);
        #2 n_reset = 1'b0;
        #1;
        n_tests++;
        if ({result, result_valid, busy, fflags, timeout_err} !== 40'd0) begin
            n_fail++;
            $display("FAIL async_reset: got res=%h v=%b busy=%b ff=%b to=%b, expected all 0",
                     result, result_valid, busy, fflags, timeout_err);
        end
        @(negedge clk);
        n_reset = 1'b1;
        model_fflags = '0;
        pulse_ready(UNIT_ADDSUB, 32'h7777_7777, 5'b11111, 1'b0);
        n_tests++;
        if ({result_valid, busy, fflags} !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_stray_ready: got v=%b busy=%b ff=%b, expected 0 0 00000",
                     result_valid, busy, fflags);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_flags();
        test_wrong_unit();
        test_kill();
        test_timeout();
        test_back_to_back();
        test_async_reset();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
